// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the fetch stage.
package instruction_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
module next_pc_select (
   input  logic [31:0] i_pc_plus4,
   input  logic [31:0] i_branch_offset,
   input  logic [25:0] i_jump_target,
   input  logic        i_jump,
   input  logic        i_branch_taken,
   output logic [31:0] o_next_pc
);

   logic [31:0] w_branch_target;
   logic [31:0] w_jump_addr;
   logic        w_unused_offset_hi;

   // Word offset; the top two bits fall off the left when scaled by 4.
   assign w_branch_target    = i_pc_plus4 + {i_branch_offset[29:0], 2'b00};
   assign w_jump_addr        = {i_pc_plus4[31:28], i_jump_target, 2'b00};
   assign w_unused_offset_hi = ^i_branch_offset[31:30];

   always_comb begin
      o_next_pc = i_pc_plus4;
      if (i_jump) begin
         o_next_pc = w_jump_addr;
      end else if (i_branch_taken) begin
         o_next_pc = w_branch_target;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, instruction register and the IDLE/FETCH/EXEC handshake FSM.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_target,
   output logic [31:0] instruction,
   output logic [15:0] immediate,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_instr;
   logic         r_valid;
   logic [31:0]  w_pc_plus4;
   logic [31:0]  w_next_pc;

   assign w_pc_plus4 = r_pc + 32'd4;

   next_pc_select u_next_pc_select (
      .i_pc_plus4      (w_pc_plus4),
      .i_branch_offset (branch_offset),
      .i_jump_target   (jump_target),
      .i_jump          (jump),
      .i_branch_taken  (branch_taken),
      .o_next_pc       (w_next_pc)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_pc    <= RESET_PC;
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: r_state <= FETCH;
            FETCH: begin
               if (imem_ready) begin
                  r_instr <= imem_rdata;
                  r_valid <= 1'b1;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               if (!stall) begin
                  r_pc    <= w_next_pc;
                  r_valid <= 1'b0;
                  r_state <= FETCH;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Request depends only on registered state, never on imem_ready.
   assign imem_req    = (r_state == FETCH);
   assign imem_addr   = r_pc;
   assign instruction = r_instr;
   assign immediate   = r_instr[15:0];
   assign instr_valid = r_valid;
   assign pc          = r_pc;
   assign pc_plus4    = w_pc_plus4;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a hand-driven memory handshake.
module tb_instruction_fetch;

   logic        clk;
   logic        reset_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_offset;
   logic        jump;
   logic [25:0] jump_target;
   logic [31:0] instruction;
   logic [15:0] immediate;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;

   int n_total = 0;
   int n_pass  = 0;

   instruction_fetch #(
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_target   (jump_target),
      .instruction   (instruction),
      .immediate     (immediate),
      .instr_valid   (instr_valid),
      .pc            (pc),
      .pc_plus4      (pc_plus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One zero-wait fetch; leaves the DUT in EXEC.
   task automatic fetch_exec(input logic [31:0] word);
      imem_ready = 1'b1;
      imem_rdata = word;
      step();
      imem_ready = 1'b0;
   endtask

   initial begin
      reset_n       = 1'b0;
      imem_ready    = 1'b0;
      imem_rdata    = 32'h0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_offset = 32'h0;
      jump          = 1'b0;
      jump_target   = 26'h0;
      step();
      step();
      chk("rst_req",   {31'h0, imem_req},    32'h0);
      chk("rst_pc",    pc,                   32'h0);
      chk("rst_instr", instruction,          32'h0);
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_imm",   {16'h0, immediate},   32'h0);
      chk("rst_pc4",   pc_plus4,             32'h4);

      reset_n = 1'b1;
      step();
      chk("first_req",  {31'h0, imem_req}, 32'h1);
      chk("first_addr", imem_addr,         32'h0);
      fetch_exec(32'h2008_0005);
      chk("f0_instr", instruction,          32'h2008_0005);
      chk("f0_imm",   {16'h0, immediate},   32'h0000_0005);
      chk("f0_valid", {31'h0, instr_valid}, 32'h1);
      chk("f0_noreq", {31'h0, imem_req},    32'h0);
      step();
      chk("seq_addr",  imem_addr,            32'h4);
      chk("seq_valid", {31'h0, instr_valid}, 32'h0);

      for (int i = 0; i < 3; i++) begin
         chk("wait_addr",  imem_addr,            32'h4);
         chk("wait_req",   {31'h0, imem_req},    32'h1);
         chk("wait_valid", {31'h0, instr_valid}, 32'h0);
         step();
      end
      fetch_exec(32'h0800_0040);
      chk("wait_done_valid", {31'h0, instr_valid}, 32'h1);
      chk("wait_done_instr", instruction,          32'h0800_0040);

      jump        = 1'b1;
      jump_target = 26'h000_0040;
      step();
      jump = 1'b0;
      chk("jump_0x100", imem_addr, 32'h0000_0100);

      fetch_exec(32'h1000_FFFE);
      branch_taken  = 1'b1;
      branch_offset = 32'hFFFF_FFFE;
      stall         = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stall_pc",    pc,                   32'h0000_0100);
         chk("stall_instr", instruction,          32'h1000_FFFE);
         chk("stall_valid", {31'h0, instr_valid}, 32'h1);
         chk("stall_req",   {31'h0, imem_req},    32'h0);
      end
      stall = 1'b0;
      step();
      branch_taken = 1'b0;
      chk("br_back", pc, 32'h0000_00FC);
      chk("br_req",  {31'h0, imem_req}, 32'h1);

      fetch_exec(32'h0800_0040);
      jump        = 1'b1;
      jump_target = 26'h000_0040;
      step();
      jump = 1'b0;
      chk("jump_back_0x100", pc, 32'h0000_0100);

      fetch_exec(32'h1000_0003);
      branch_taken  = 1'b1;
      branch_offset = 32'h0000_0003;
      step();
      branch_taken = 1'b0;
      chk("br_fwd", pc, 32'h0000_0110);

      fetch_exec(32'h1000_FFBB);
      branch_taken  = 1'b1;
      branch_offset = 32'h03FF_FFBB;
      step();
      chk("br_far", pc, 32'h1000_0000);

      fetch_exec(32'h0800_0040);
      jump          = 1'b1;
      jump_target   = 26'h000_0040;
      branch_offset = 32'h0000_0003;
      step();
      jump = 1'b0;
      chk("jump_prio", pc, 32'h1000_0100);

      // Branch held high through FETCH must not act until EXEC.
      branch_offset = 32'h3BFF_FFBE;
      fetch_exec(32'h1000_0000);
      chk("br_ignored_fetch", pc, 32'h1000_0100);
      step();
      branch_taken = 1'b0;
      chk("br_top",     pc,       32'hFFFF_FFFC);
      chk("top_plus4",  pc_plus4, 32'h0000_0000);

      fetch_exec(32'h0000_0000);
      step();
      chk("wrap_pc", pc, 32'h0000_0000);

      fetch_exec(32'h0000_0000);
      step();
      chk("pre_rst_pc", pc, 32'h0000_0004);
      reset_n    = 1'b0;
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      step();
      chk("rf_req",   {31'h0, imem_req},    32'h0);
      chk("rf_pc",    pc,                   32'h0);
      chk("rf_valid", {31'h0, instr_valid}, 32'h0);
      chk("rf_instr", instruction,          32'h0);
      step();
      chk("rf_idle_instr", instruction, 32'h0);
      imem_ready = 1'b0;
      reset_n    = 1'b1;
      step();
      chk("rf_refetch_req", {31'h0, imem_req}, 32'h1);
      chk("rf_late_ready",  instruction,       32'h0);

      fetch_exec(32'h1234_5678);
      chk("re_valid", {31'h0, instr_valid}, 32'h1);
      reset_n = 1'b0;
      step();
      chk("re_instr", instruction,          32'h0);
      chk("re_valid_clr", {31'h0, instr_valid}, 32'h0);
      reset_n = 1'b1;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
